// File: rtl/um_pkg.sv
// Shared types and helpers for the UM transmit flow-control block.
package um_pkg;

  typedef enum logic [1:0] {
    OFF = 2'd0,
    ARM = 2'd1,
    ON  = 2'd2
  } um_state_e;

  localparam int NUM_BID_DEF = 8;
  localparam int CNT_W       = $clog2(NUM_BID_DEF + 1);
  localparam int POP_MAX     = 64;

  // Counts set bits; callers zero-extend narrower bitmaps to POP_MAX.
  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/um_tx_flow_ctrl_if.sv
// CDP/pktBuffer-facing signal bundle of the UM transmit gate, including config and statistics.
interface um_tx_flow_ctrl_if #(
  parameter int NUM_BID = 8,
  parameter int TS_W    = 32,
  parameter int STAT_W  = 16
);
  localparam int CNT_W = $clog2(NUM_BID + 1);

  logic               cdp2um_data_valid;
  logic [NUM_BID-1:0] bid_bitmap;
  logic               cfg_valid;
  logic [CNT_W-1:0]   cfg_on_thresh;
  logic [CNT_W-1:0]   cfg_off_thresh;
  logic               cfg_err;
  logic               um2cdp_tx_enable;
  logic [CNT_W-1:0]   free_cnt;
  logic [TS_W-1:0]    count_time;
  logic [STAT_W-1:0]  tx_on_events;
  logic [STAT_W-1:0]  stall_cycles;

  modport master (
    output cdp2um_data_valid, bid_bitmap, cfg_valid, cfg_on_thresh, cfg_off_thresh,
    input  cfg_err, um2cdp_tx_enable, free_cnt, count_time, tx_on_events, stall_cycles
  );

  modport slave (
    input  cdp2um_data_valid, bid_bitmap, cfg_valid, cfg_on_thresh, cfg_off_thresh,
    output cfg_err, um2cdp_tx_enable, free_cnt, count_time, tx_on_events, stall_cycles
  );

endinterface

// File: rtl/um_tx_flow_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module um_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/um_tx_flow_ctrl.sv
// UM transmit gate: enables CDP->UM transfers when enough packet buffers are free,
// with on/off hysteresis, a qualification hold, a timestamp and saturating stats.
module um_tx_flow_ctrl
  import um_pkg::*;
#(
  parameter int NUM_BID    = 8,
  parameter int ON_THRESH  = 8,
  parameter int OFF_THRESH = 4,
  parameter int HOLD_CYC   = 4,
  parameter int TS_W       = 32,
  parameter int STAT_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  um_tx_flow_ctrl_if.slave bus
);

  localparam int LCL_CNT_W = $clog2(NUM_BID + 1);
  localparam int HOLD_W    = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);

  localparam logic [LCL_CNT_W-1:0] ON_RST    = LCL_CNT_W'(ON_THRESH);
  localparam logic [LCL_CNT_W-1:0] OFF_RST   = LCL_CNT_W'(OFF_THRESH);
  localparam logic [LCL_CNT_W-1:0] NUM_BID_C = LCL_CNT_W'(NUM_BID);
  localparam logic [HOLD_W-1:0]    HOLD_C    = HOLD_W'(HOLD_CYC);

  logic [LCL_CNT_W-1:0] free_cnt_q, free_cnt_d;
  logic                 dv_q, dv_d;
  logic [LCL_CNT_W-1:0] on_th_q, on_th_d;
  logic [LCL_CNT_W-1:0] off_th_q, off_th_d;
  um_state_e            state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                 tx_en_q, tx_en_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [TS_W-1:0]      count_time_q, count_time_d;

  logic qual, drop, cfg_ok, enter_on;

  // Stage 1: capture buffer occupancy and CDP activity
  always_comb begin
    free_cnt_d = LCL_CNT_W'(popcount(POP_MAX'(bus.bid_bitmap)));
    dv_d       = bus.cdp2um_data_valid;
  end

  // Stage 2: enable decision from captured values and current thresholds
  always_comb begin
    qual       = !dv_q && (free_cnt_q >= on_th_q);
    drop       = dv_q || (free_cnt_q < off_th_q);
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      OFF: begin
        if (qual) begin
          if (HOLD_CYC == 0) begin
            state_d = ON;
          end else begin
            state_d    = ARM;
            hold_cnt_d = HOLD_W'(1);
          end
        end
      end
      ARM: begin
        if (!qual) begin
          state_d    = OFF;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_C) begin
          state_d = ON;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ON: begin
        if (drop) state_d = OFF;
      end
      default: state_d = OFF;
    endcase
    tx_en_d  = (state_d == ON);
    enter_on = (state_d == ON) && (state_q != ON);
  end

  // Threshold writes land after this edge, so the decision above never sees them early
  always_comb begin
    cfg_ok = (bus.cfg_off_thresh <= bus.cfg_on_thresh) &&
             (bus.cfg_on_thresh <= NUM_BID_C) &&
             (bus.cfg_on_thresh != '0);
    on_th_d   = on_th_q;
    off_th_d  = off_th_q;
    cfg_err_d = 1'b0;
    if (bus.cfg_valid) begin
      if (cfg_ok) begin
        on_th_d  = bus.cfg_on_thresh;
        off_th_d = bus.cfg_off_thresh;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
    count_time_d = count_time_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_cnt_q   <= '0;
      dv_q         <= 1'b0;
      on_th_q      <= ON_RST;
      off_th_q     <= OFF_RST;
      state_q      <= OFF;
      hold_cnt_q   <= '0;
      tx_en_q      <= 1'b0;
      cfg_err_q    <= 1'b0;
      count_time_q <= '0;
    end else begin
      free_cnt_q   <= free_cnt_d;
      dv_q         <= dv_d;
      on_th_q      <= on_th_d;
      off_th_q     <= off_th_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      tx_en_q      <= tx_en_d;
      cfg_err_q    <= cfg_err_d;
      count_time_q <= count_time_d;
    end
  end

  um_sat_counter #(.W(STAT_W)) u_on_events (
    .clk   (clk),
    .clear (rst),
    .inc   (enter_on),
    .cnt   (bus.tx_on_events)
  );

  um_sat_counter #(.W(STAT_W)) u_stall (
    .clk   (clk),
    .clear (rst),
    .inc   (!tx_en_q),
    .cnt   (bus.stall_cycles)
  );

  assign bus.free_cnt         = free_cnt_q;
  assign bus.um2cdp_tx_enable = tx_en_q;
  assign bus.cfg_err          = cfg_err_q;
  assign bus.count_time       = count_time_q;

endmodule

// File: tb/tb_um_tx_flow_ctrl.sv
// Scoreboard bench for um_tx_flow_ctrl: directed scenarios plus randomized traffic.
module tb_um_tx_flow_ctrl;
  import um_pkg::*;

  localparam int NB   = 8;
  localparam int HOLD = 4;
  localparam int TSW  = 16;
  localparam int SW   = 16;
  localparam int CW   = $clog2(NB + 1);
  localparam int TMOD = 1 << TSW;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  um_tx_flow_ctrl_if #(.NUM_BID(NB), .TS_W(TSW), .STAT_W(SW)) bus ();

  um_tx_flow_ctrl #(
    .NUM_BID(NB), .ON_THRESH(8), .OFF_THRESH(4), .HOLD_CYC(HOLD), .TS_W(TSW), .STAT_W(SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit chk;
    bit tx;
    int fc;
    int t;
    int ev;
    int st;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: thresholds, last captured sample, qualifying run length, enable flag
  int m_on = 8, m_off = 4, m_cap_fc = 0, m_run = 0, m_time = 0, m_ev = 0, m_st = 0;
  bit m_cap_dv = 0, m_en = 0, m_err = 0;

  task automatic cmp(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs, predict outputs after the coming edge, wait for the next negedge
  task automatic step(input bit r, input bit dv, input logic [NB-1:0] bm,
                      input bit cv, input int con, input int coff, input bit chk);
    exp_t e;
    bit qual, drop, acc;
    rst                   = r;
    bus.cdp2um_data_valid = dv;
    bus.bid_bitmap        = bm;
    bus.cfg_valid         = cv;
    bus.cfg_on_thresh     = CW'(con);
    bus.cfg_off_thresh    = CW'(coff);
    if (r) begin
      m_on = 8; m_off = 4; m_cap_fc = 0; m_cap_dv = 0; m_run = 0;
      m_en = 0; m_time = 0; m_ev = 0; m_st = 0; m_err = 0;
    end else begin
      qual = !m_cap_dv && (m_cap_fc >= m_on);
      drop = m_cap_dv || (m_cap_fc < m_off);
      if (!m_en && m_st < SMAX) m_st++;
      m_time = (m_time + 1) % TMOD;
      if (m_en) begin
        if (drop) begin m_en = 0; m_run = 0; end
      end else begin
        m_run = qual ? m_run + 1 : 0;
        if (m_run > HOLD) begin
          m_en = 1; m_run = 0;
          if (m_ev < SMAX) m_ev++;
        end
      end
      acc   = (coff <= con) && (con <= NB) && (con != 0);
      m_err = cv && !acc;
      if (cv && acc) begin m_on = con; m_off = coff; end
      m_cap_fc = $countones(bm);
      m_cap_dv = dv;
    end
    e.chk = chk; e.tx = m_en; e.fc = m_cap_fc; e.t = m_time;
    e.ev = m_ev; e.st = m_st; e.err = m_err;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          cmp("tx_enable",    int'(bus.um2cdp_tx_enable), int'(e.tx));
          cmp("free_cnt",     int'(bus.free_cnt),         e.fc);
          cmp("count_time",   int'(bus.count_time),       e.t);
          cmp("tx_on_events", int'(bus.tx_on_events),     e.ev);
          cmp("stall_cycles", int'(bus.stall_cycles),     e.st);
          cmp("cfg_err",      int'(bus.cfg_err),          int'(e.err));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_tx(input string nm, input int expv);
    int lat;
    lat = 0;
    while (lat < 20) begin
      step(0, 0, 8'hff, 0, 0, 0, 1);
      lat++;
      if (bus.um2cdp_tx_enable) break;
    end
    cmp(nm, lat, expv);
  endtask

  initial begin
    logic [NB-1:0] bm;
    bit chk;
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 0, 0, 0, 1);

    // Fresh qualification: capture + decision + 4-cycle hold
    wait_tx("t1_latency", 6);
    cmp("t1_events", int'(bus.tx_on_events), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 8'hff, 0, 0, 0, 1);

    // Hysteresis band
    for (int i = 0; i < 5; i++) step(0, 0, 8'h3f, 0, 0, 0, 1);
    cmp("t2_hold_high", int'(bus.um2cdp_tx_enable), 1);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h07, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h3f, 0, 0, 0, 1);
    cmp("t2_stay_low", int'(bus.um2cdp_tx_enable), 0);

    // Abort during ARM, then a full re-qualification
    for (int i = 0; i < 3; i++) step(0, 0, 8'hff, 0, 0, 0, 1);
    step(0, 1, 8'hff, 0, 0, 0, 1);
    wait_tx("t3_requal_latency", 6);

    // Rejected then accepted threshold writes
    step(0, 0, 8'hff, 1, 2, 5, 1);
    cmp("t4_cfg_err", int'(bus.cfg_err), 1);
    step(0, 0, 8'hff, 1, 3, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 8'h07, 0, 0, 0, 1);
    cmp("t4_free3_on", int'(bus.um2cdp_tx_enable), 1);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0, 0, 0, 1);
    cmp("t4_free0_off", int'(bus.um2cdp_tx_enable), 0);
    for (int i = 0; i < 8; i++) step(0, 0, 8'h07, 0, 0, 0, 1);

    // Reset while enabled at count_time 1000; thresholds must revert
    while (m_time < 1000) step(0, 0, 8'h07, 0, 0, 0, 1);
    step(1, 0, 8'h07, 1, 2, 1, 1);
    cmp("t5_time_cleared", int'(bus.count_time), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h07, 0, 0, 0, 1);
    cmp("t5_default_thresh", int'(bus.um2cdp_tx_enable), 0);

    // Randomized traffic with occasional config writes and resets
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: bm = 8'hff;
        1: bm = 8'h3f;
        2: bm = 8'h07;
        default: bm = NB'($urandom);
      endcase
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) == 0), bm,
           ($urandom_range(0, 19) == 0), int'($urandom_range(0, 9)),
           int'($urandom_range(0, 9)), 1);
    end

    // Long stall: timestamp wrap and stall counter saturation
    for (int i = 0; i < TMOD + 8; i++) begin
      chk = (m_time >= TMOD - 6) || (m_time < 4);
      step(0, 1, 8'hff, 0, 0, 0, chk);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0, 0, 0, 1);
    cmp("t6_stall_sat", int'(bus.stall_cycles), SMAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
